// File: rtl/serial_sub.sv
// Bit-serial LSB-first unsigned subtractor with valid/ready handshakes on both sides.
// Optional SERIAL_SUB_ADD_EN adds a mode input: mode=1 adds and reports carry-out on borrow.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_ADD_EN
  input  logic             mode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready=1
  // RUN   | shifting one bit per cycle, WIDTH cycles
  // DONE  | result presented, waiting for out_ready
  localparam int CW = $clog2(WIDTH + 1);

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("serial_sub: WIDTH must be in 2..32");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb, sd;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             borrow_r;
  logic             sub;
  logic             load_sub;
  logic             accept;
  logic             last_bit;
  logic             b_bit;
  logic             d_bit;
  logic             c_next;

  // sub selects b inversion and the polarity of the reported carry-out.
`ifdef SERIAL_SUB_ADD_EN
  logic sub_r;
  assign load_sub = ~mode;
  assign sub      = sub_r;
`else
  assign load_sub = 1'b1;
  assign sub      = 1'b1;
`endif

  assign b_bit  = sb[0] ^ sub;
  assign d_bit  = sa[0] ^ b_bit ^ carry;
  assign c_next = (sa[0] & b_bit) | (sa[0] & carry) | (b_bit & carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    last_bit   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        last_bit = (cnt == CW'(WIDTH - 1));
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      sd       <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      borrow_r <= 1'b0;
`ifdef SERIAL_SUB_ADD_EN
      sub_r    <= 1'b0;
`endif
    end else if (accept) begin
      sa    <= a;
      sb    <= b;
      sd    <= '0;
      carry <= load_sub;
      cnt   <= '0;
`ifdef SERIAL_SUB_ADD_EN
      sub_r <= load_sub;
`endif
    end else if (state == RUN) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      sd    <= {d_bit, sd[WIDTH-1:1]};
      carry <= c_next;
      cnt   <= cnt + CW'(1);
      // Subtract reports inverted carry-out (borrow); add reports carry-out directly.
      if (last_bit) borrow_r <= c_next ^ sub;
    end
  end

  assign diff   = sd;
  assign borrow = borrow_r;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: driver pushes expected results, negedge monitor pops and compares.
module tb_serial_sub;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, borrow;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_ADD_EN
  logic         mode = 1'b0;
`endif

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
`ifdef SERIAL_SUB_ADD_EN
    .mode(mode),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference: plain unsigned arithmetic, no bit-level modelling.
  function automatic exp_t model(int unsigned x, int unsigned y, bit add);
    exp_t e;
    int unsigned r;
    if (add) begin
      r    = x + y;
      e.d  = W'(r);
      e.br = (r >= (1 << W));
    end else begin
      r    = x - y;
      e.d  = W'(r);
      e.br = (x < y);
    end
    e.acc = 0;
    return e;
  endfunction

  // Monitor
  logic prev_v = 1'b0;
  logic hs_prev = 1'b0;
  always @(negedge clk) begin
    exp_t cur;
    if (!rst_n) begin
      prev_v  = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) begin
        check("in_ready_after_handshake", in_ready, 1);
        check("out_valid_after_handshake", out_valid, 0);
      end
      hs_prev = 1'b0;
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          cur = q[0];
          if (!prev_v) check("latency", cyc - cur.acc, W);
          check("diff", diff, cur.d);
          check("borrow", borrow, cur.br);
          check("in_ready_in_done", in_ready, 0);
          if (out_ready) begin
            void'(q.pop_front());
            hs_prev = 1'b1;
          end
        end
      end
      prev_v = out_valid;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input bit md);
    int n = 0;
    exp_t e;
    a = x;
    b = y;
`ifdef SERIAL_SUB_ADD_EN
    mode = md;
`endif
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
    end else begin
`ifdef SERIAL_SUB_ADD_EN
      e = model(x, y, md);
`else
      e = model(x, y, 1'b0);
`endif
      e.acc = cyc + 1;
      q.push_back(e);
      step();
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 300) begin
      step();
      n++;
    end
    if (q.size() > 0) check("drain_timeout", q.size(), 0);
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) step();
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_diff", diff, 0);
    check("reset_borrow", borrow, 0);
    rst_n = 1'b1;
    step();

    // Basic subtract
    send(8'h35, 8'h12, 1'b0);
    in_valid = 1'b0;
    drain();

    // Back-to-back with in_valid held high
    send(8'h00, 8'h01, 1'b0);
    send(8'hAA, 8'hAA, 1'b0);
    in_valid = 1'b0;
    drain();

    // Result held under backpressure
    out_ready = 1'b0;
    send(8'h80, 8'h7F, 1'b0);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin
      step();
      n++;
    end
    if (!out_valid) check("out_valid_timeout", out_valid, 1);
    repeat (5) step();
    out_ready = 1'b1;
    drain();

    // Operand changes and in_valid pulse during RUN are ignored
    send(8'h35, 8'h12, 1'b0);
    in_valid = 1'b0;
    step();
    step();
    a = 8'hFF;
    b = 8'h01;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 8'h5A;
    b = 8'hC3;
    drain();
    repeat (12) step();

    // Reset mid-RUN
    send(8'h35, 8'h12, 1'b0);
    in_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    q.delete();
    #1;
    check("midrun_reset_in_ready", in_ready, 1);
    check("midrun_reset_out_valid", out_valid, 0);
    check("midrun_reset_diff", diff, 0);
    check("midrun_reset_borrow", borrow, 0);
    step();
    rst_n = 1'b1;
    repeat (12) step();
    send(8'h10, 8'h20, 1'b0);
    in_valid = 1'b0;
    drain();

    // Boundary: a=0, b=max
    send(8'h00, 8'hFF, 1'b0);
    in_valid = 1'b0;
    drain();

`ifdef SERIAL_SUB_ADD_EN
    send(8'hFF, 8'h01, 1'b1);
    send(8'h12, 8'h34, 1'b1);
    send(8'h12, 8'h34, 1'b0);
    in_valid = 1'b0;
    drain();
`endif

    // Randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) step();
    end
    in_valid = 1'b0;
    rand_rdy = 1'b0;
    step();
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial unsigned subtractor, LSB-first. Computes diff = a - b and a borrow flag, one bit per clock.
- Datapath per bit: one 3-input XOR gives the sum bit and one 3-input majority gives the carry, with b inverted and carry-in 1 (two's-complement subtract).
- Sits beside the arithmetic cell library as a low-area alternative to a parallel subtractor.
- Handshaked on both sides so it drops into a valid/ready stream.

Parameters:
- WIDTH, 8, operand and result width in bits. Legal range 2..32.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a and b are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  diff and borrow are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a - b mod 2^WIDTH.
- borrow  output  1  1 when a < b (unsigned).

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values, all forced immediately while rst_n=0:
  - state=IDLE, in_ready=1, out_valid=0, diff=0, borrow=0.
  - internal shift registers, carry and bit counter = 0.
- State machine, states IDLE, RUN, DONE:
  - IDLE: in_ready=1. On in_valid & in_ready at an edge:
    - load a into shift register SA and b into SB
    - carry=1, counter=0, clear the diff shift register
    - go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle:
    - bit d = SA[0] ^ ~SB[0] ^ carry
    - carry <= maj(SA[0], ~SB[0], carry)
    - SA and SB shift right one place
    - d shifts into the diff register at the MSB, so the value is LSB-aligned after WIDTH shifts
    - counter increments.
    - After the WIDTH-th shift, go to DONE and latch borrow = ~carry_final.
  - DONE: out_valid=1 and in_ready=0. diff and borrow hold stable. On out_ready=1 at an edge, go to IDLE.
- Latency:
  - out_valid rises exactly WIDTH cycles after the accepting edge.
  - Throughput is one operation per WIDTH+2 cycles minimum; there is no overlap of accept with DONE.
- Inputs a and b are sampled only at the accepting edge. Later changes have no effect.
- in_valid is ignored outside IDLE; no operand is queued.
- out_ready is ignored outside DONE.
- diff and borrow are don't-care while out_valid=0. diff holds its old value until it is reloaded.
- Arithmetic: modulo 2^WIDTH. borrow is the inverted carry-out of a + ~b + 1.
  - a == b gives diff=0, borrow=0.
  - a=0, b=max gives diff=1, borrow=1.
- Counter width is clog2(WIDTH+1). It never wraps in normal operation and is cleared on every accept.
- Reset mid-RUN or mid-DONE:
  - aborts immediately to IDLE with the reset values
  - no out_valid pulse for the aborted operation.
- in_valid and out_ready both high in DONE: only the result handshake completes. The new operand is accepted at the first edge in IDLE.

Optional Feature:
- Macro: SERIAL_SUB_ADD_EN.
- Defined:
  - Adds input port mode (1 bit), sampled at the accepting edge.
  - mode=1 selects addition: b is not inverted, carry-in=0, and the borrow port reports the true carry-out (the overflow of a+b).
  - mode=0 behaves exactly as subtract.
- Undefined:
  - No mode port; subtract only.
  - Gate count is identical apart from the b-inversion mux.

Test Plan:
- WIDTH=8, a=0x35, b=0x12, out_ready=1 → out_valid high exactly 8 cycles after the accept edge, diff=0x23, borrow=0. in_ready returns 1 the cycle after the DONE handshake.
- a=0x00, b=0x01 → diff=0xFF, borrow=1. Then a=0xAA, b=0xAA → diff=0x00, borrow=0, issued back-to-back with in_valid held high.
- a=0x80, b=0x7F with out_ready held 0 for 5 cycles after out_valid → diff=0x01 and borrow=0 held stable, in_ready=0 throughout. Handshake completes on the first out_ready=1 edge.
- Change a/b and pulse in_valid during RUN → result is unaffected (0x35-0x12 still gives 0x23) and no second operation starts.
- Assert rst_n=0 at RUN count 4, release, then issue a=0x10, b=0x20 → no stale out_valid. Result diff=0xF0, borrow=1 after 8 cycles.
- With SERIAL_SUB_ADD_EN defined:
  - mode=1, a=0xFF, b=0x01 → diff=0x00, borrow(carry)=1
  - mode=1, a=0x12, b=0x34 → diff=0x46, borrow=0.
